// File: rtl/hough_pkg.sv
// Shared types and helpers for the Hough image-path front end:
// line timing state encoding, geometry width and the configuration legality check.
package hough_pkg;

  localparam int unsigned W_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } lg_state_t;

  // Period is summed one bit wider so Width+Blank cannot wrap before the limit check.
  function automatic logic cfg_legal(input logic [W_BITS-1:0] width,
                                     input logic [W_BITS-1:0] blank,
                                     input logic [W_BITS-1:0] height);
    logic [W_BITS:0] sum;
    sum = {1'b0, width} + {1'b0, blank};
    return (width != '0) && (height != '0) &&
           (sum <= (W_BITS+1)'((1 << W_BITS) - 1));
  endfunction

endpackage

// File: rtl/line_gen_if.sv
// Line timing bundle: frame request/geometry in, pixel timing and status out.
interface line_gen_if;
  import hough_pkg::*;

  logic              Start;
  logic [W_BITS-1:0] Width;
  logic [W_BITS-1:0] Blank;
  logic [W_BITS-1:0] Height;
  logic              Busy;
  logic              Valid;
  logic [W_BITS-1:0] X;
  logic [W_BITS-1:0] Y;
  logic              Line;
  logic              Frame;
  logic              Err;

  modport master (
    input  Start, Width, Blank, Height,
    output Busy, Valid, X, Y, Line, Frame, Err
  );

  modport slave (
    output Start, Width, Blank, Height,
    input  Busy, Valid, X, Y, Line, Frame, Err
  );

endinterface

// File: rtl/mod_counter.sv
// Loadable terminal-count counter: counts 0..term, with clear, enable and
// last/penultimate/single-count flags used for one-cycle-ahead pulse generation.
module mod_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_term,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q,
  output logic         o_last,
  output logic         o_penult,
  output logic         o_single
);

  logic [W-1:0] r_q;
  logic [W-1:0] r_term;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_term <= '0;
    end else begin
      if (i_load) r_term <= i_term;
      if (i_clr)     r_q <= '0;
      else if (i_en) r_q <= o_last ? '0 : r_q + 1'b1;
    end
  end

  assign o_q      = r_q;
  assign o_last   = (r_q == r_term);
  assign o_penult = (({1'b0, r_q} + 1'b1) == {1'b0, r_term});
  assign o_single = (r_term == '0);

endmodule

// File: rtl/line_gen.sv
// Line-synchronised pixel timing source: one Start yields Height lines of
// Width active cycles plus Blank idle cycles, with registered Line/Frame pulses.
module line_gen
  import hough_pkg::*;
(
  input  logic       Clk,
  input  logic       nReset,
  line_gen_if.master bus
);

  lg_state_t         r_state;
  logic              r_busy, r_valid, r_line, r_frame, r_err, r_has_blank;
  lg_state_t         w_nxt_state;
  logic              w_nxt_busy, w_nxt_valid, w_nxt_line, w_nxt_frame, w_nxt_err;
  logic              w_load, w_eol, w_cfg_ok;
  logic              w_x_clr, w_x_en, w_b_clr, w_b_en, w_y_clr, w_y_en;
  logic [W_BITS-1:0] w_x_q, w_b_q, w_y_q;
  logic              w_x_last, w_x_penult, w_x_single;
  logic              w_b_last, w_b_penult, w_b_single;
  logic              w_y_last, w_y_penult, w_y_single;
  logic              w_unused;

  assign w_cfg_ok = cfg_legal(bus.Width, bus.Blank, bus.Height);
  assign w_unused = &{1'b0, w_y_single, w_b_q};

  mod_counter #(.W(W_BITS)) u_x_cnt (
    .i_clk(Clk), .i_rst_n(nReset), .i_load(w_load), .i_term(bus.Width - 1'b1),
    .i_clr(w_x_clr), .i_en(w_x_en), .o_q(w_x_q),
    .o_last(w_x_last), .o_penult(w_x_penult), .o_single(w_x_single)
  );

  mod_counter #(.W(W_BITS)) u_b_cnt (
    .i_clk(Clk), .i_rst_n(nReset), .i_load(w_load), .i_term(bus.Blank - 1'b1),
    .i_clr(w_b_clr), .i_en(w_b_en), .o_q(w_b_q),
    .o_last(w_b_last), .o_penult(w_b_penult), .o_single(w_b_single)
  );

  mod_counter #(.W(W_BITS)) u_y_cnt (
    .i_clk(Clk), .i_rst_n(nReset), .i_load(w_load), .i_term(bus.Height - 1'b1),
    .i_clr(w_y_clr), .i_en(w_y_en), .o_q(w_y_q),
    .o_last(w_y_last), .o_penult(w_y_penult), .o_single(w_y_single)
  );

  // Line/Frame are registered, so each is decided one cycle early from the
  // counters' penultimate flags; X and blank counts sit at 0 outside their state.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_busy  = r_busy;
    w_nxt_valid = 1'b0;
    w_nxt_line  = 1'b0;
    w_nxt_frame = 1'b0;
    w_nxt_err   = 1'b0;
    w_load      = 1'b0;
    w_eol       = 1'b0;
    w_x_clr     = 1'b0;
    w_x_en      = 1'b0;
    w_b_clr     = 1'b0;
    w_b_en      = 1'b0;
    w_y_clr     = 1'b0;
    w_y_en      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.Start) begin
          if (w_cfg_ok) begin
            w_load      = 1'b1;
            w_nxt_state = ST_ACTIVE;
            w_nxt_busy  = 1'b1;
            w_nxt_valid = 1'b1;
            w_nxt_line  = (bus.Width == W_BITS'(1)) && (bus.Blank == '0);
            w_nxt_frame = w_nxt_line && (bus.Height == W_BITS'(1));
          end else begin
            w_nxt_err = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (!w_x_last) begin
          w_x_en      = 1'b1;
          w_nxt_valid = 1'b1;
          w_nxt_line  = w_x_penult && !r_has_blank;
          w_nxt_frame = w_nxt_line && w_y_last;
        end else if (r_has_blank) begin
          w_x_clr     = 1'b1;
          w_nxt_state = ST_BLANK;
          w_nxt_line  = w_b_single;
          w_nxt_frame = w_nxt_line && w_y_last;
        end else begin
          w_eol = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!w_b_last) begin
          w_b_en      = 1'b1;
          w_nxt_line  = w_b_penult;
          w_nxt_frame = w_nxt_line && w_y_last;
        end else begin
          w_eol = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    if (w_eol) begin
      w_x_clr = 1'b1;
      w_b_clr = 1'b1;
      if (w_y_last) begin
        w_nxt_state = ST_IDLE;
        w_nxt_busy  = 1'b0;
        w_y_clr     = 1'b1;
      end else begin
        w_y_en      = 1'b1;
        w_nxt_state = ST_ACTIVE;
        w_nxt_valid = 1'b1;
        w_nxt_line  = w_x_single && !r_has_blank;
        w_nxt_frame = w_nxt_line && w_y_penult;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_line      <= 1'b0;
      r_frame     <= 1'b0;
      r_err       <= 1'b0;
      r_has_blank <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_busy  <= w_nxt_busy;
      r_valid <= w_nxt_valid;
      r_line  <= w_nxt_line;
      r_frame <= w_nxt_frame;
      r_err   <= w_nxt_err;
      if (w_load) r_has_blank <= (bus.Blank != '0);
    end
  end

  assign bus.Busy  = r_busy;
  assign bus.Valid = r_valid;
  assign bus.X     = w_x_q;
  assign bus.Y     = w_y_q;
  assign bus.Line  = r_line;
  assign bus.Frame = r_frame;
  assign bus.Err   = r_err;

endmodule

// File: tb/tb_line_gen.sv
// Directed bench for line_gen: table of frame geometries with hand-computed
// totals, plus sequences for waveform shape, held Start, relatch and reset.
module tb_line_gen;
  import hough_pkg::*;

  typedef struct {
    logic [7:0] w;
    logic [7:0] b;
    logic [7:0] h;
    int         legal;
    int         busy;
    int         lines;
    int         valid;
  } vec_t;

  logic Clk = 1'b0;
  logic nReset;
  line_gen_if lg();

  line_gen dut (.Clk(Clk), .nReset(nReset), .bus(lg));

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  int g_busy, g_lines, g_valid, g_frames, g_flast, g_bad_period, g_bad_x;
  int g_err_first, g_err_during, g_frame_no_line;
  logic [63:0] g_vpat, g_lpat, g_fpat;
  int g_x[16];
  int g_y[16];

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Requests one frame and records its timing until Busy falls (bounded).
  task automatic run_frame(input logic [7:0] w, input logic [7:0] b,
                           input logic [7:0] h, input int period,
                           input bit hold, input logic [7:0] w_late);
    int cyc;
    int prev;
    cyc = 0;
    prev = 0;
    g_lines = 0; g_valid = 0; g_frames = 0; g_flast = 0;
    g_bad_period = 0; g_bad_x = 0; g_err_during = 0; g_frame_no_line = 0;
    g_vpat = '0; g_lpat = '0; g_fpat = '0;
    for (int i = 0; i < 16; i++) begin g_x[i] = -1; g_y[i] = -1; end
    lg.Width = w; lg.Blank = b; lg.Height = h; lg.Start = 1'b1;
    tick();
    if (!hold) lg.Start = 1'b0;
    g_err_first = int'(lg.Err);
    while (lg.Busy && cyc < 2000) begin
      cyc++;
      if (cyc == 3) lg.Width = w_late;
      g_vpat = {g_vpat[62:0], lg.Valid};
      g_lpat = {g_lpat[62:0], lg.Line};
      g_fpat = {g_fpat[62:0], lg.Frame};
      if (cyc <= 16) begin g_x[cyc-1] = int'(lg.X); g_y[cyc-1] = int'(lg.Y); end
      if (lg.Valid) g_valid++;
      if (lg.Err) g_err_during++;
      if (!lg.Valid && lg.X != '0) g_bad_x++;
      if (lg.Line) begin
        g_lines++;
        if (cyc - prev != period) g_bad_period++;
        prev = cyc;
      end
      if (lg.Frame) begin
        g_frames++;
        g_flast = cyc;
        if (!lg.Line) g_frame_no_line++;
      end
      tick();
    end
    g_busy = cyc;
    lg.Width = w;
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{8'd4,   8'd2,   8'd2, 1, 12,  2, 8};
    vecs[1]  = '{8'd1,   8'd0,   8'd3, 1, 3,   3, 3};
    vecs[2]  = '{8'd200, 8'd56,  8'd1, 0, 0,   0, 0};
    vecs[3]  = '{8'd0,   8'd5,   8'd2, 0, 0,   0, 0};
    vecs[4]  = '{8'd5,   8'd0,   8'd0, 0, 0,   0, 0};
    vecs[5]  = '{8'd3,   8'd1,   8'd2, 1, 8,   2, 6};
    vecs[6]  = '{8'd255, 8'd0,   8'd1, 1, 255, 1, 255};
    vecs[7]  = '{8'd100, 8'd155, 8'd1, 1, 255, 1, 100};
    vecs[8]  = '{8'd255, 8'd1,   8'd1, 0, 0,   0, 0};
    vecs[9]  = '{8'd2,   8'd3,   8'd3, 1, 15,  3, 6};
    vecs[10] = '{8'd1,   8'd254, 8'd2, 1, 510, 2, 2};

    nReset = 1'b0;
    lg.Start = 1'b0; lg.Width = '0; lg.Blank = '0; lg.Height = '0;
    #3;
    chk("reset_outputs", int'({lg.Busy, lg.Valid, lg.X, lg.Y, lg.Line, lg.Frame, lg.Err}), 0);
    tick(); tick();
    nReset = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_frame(vecs[i].w, vecs[i].b, vecs[i].h,
                int'(vecs[i].w) + int'(vecs[i].b), 1'b0, vecs[i].w);
      chk($sformatf("v%0d_err", i), g_err_first, 1 - vecs[i].legal);
      chk($sformatf("v%0d_busy", i), g_busy, vecs[i].busy);
      chk($sformatf("v%0d_lines", i), g_lines, vecs[i].lines);
      chk($sformatf("v%0d_valid", i), g_valid, vecs[i].valid);
      chk($sformatf("v%0d_period", i), g_bad_period, 0);
      chk($sformatf("v%0d_frames", i), g_frames, vecs[i].legal);
      chk($sformatf("v%0d_frame_last", i), g_flast, vecs[i].busy);
      chk($sformatf("v%0d_frame_on_line", i), g_frame_no_line, 0);
      chk($sformatf("v%0d_x_idle", i), g_bad_x, 0);
      tick();
      chk($sformatf("v%0d_after_busy_err", i), int'({lg.Busy, lg.Err}), 0);
    end

    // Exact waveform shape for 4/2/2.
    run_frame(8'd4, 8'd2, 8'd2, 6, 1'b0, 8'd4);
    chk("w4_valid_pat", int'(g_vpat[11:0]), 12'b111100111100);
    chk("w4_line_pat",  int'(g_lpat[11:0]), 12'b000001000001);
    chk("w4_frame_pat", int'(g_fpat[11:0]), 12'b000000000001);
    chk("w4_x_seq", g_x[0]*1000 + g_x[1]*100 + g_x[2]*10 + g_x[3], 123);
    chk("w4_y_second", g_y[6], 1);
    tick();

    // Single-pixel lines, no blanking.
    run_frame(8'd1, 8'd0, 8'd3, 1, 1'b0, 8'd1);
    chk("w1_valid_pat", int'(g_vpat[2:0]), 3'b111);
    chk("w1_line_pat",  int'(g_lpat[2:0]), 3'b111);
    chk("w1_frame_pat", int'(g_fpat[2:0]), 3'b001);
    chk("w1_x_zero", g_x[0] + g_x[1] + g_x[2], 0);
    chk("w1_y_seq", g_y[0]*100 + g_y[1]*10 + g_y[2], 12);
    tick();

    // Start held high: ignored mid-frame, re-accepted on the first idle cycle.
    run_frame(8'd3, 8'd1, 8'd2, 4, 1'b1, 8'd3);
    chk("hold_err_first", g_err_first, 0);
    chk("hold_err_during", g_err_during, 0);
    chk("hold_busy", g_busy, 8);
    chk("hold_gap_idle", int'({lg.Busy, lg.Valid, lg.Err}), 0);
    tick();
    lg.Start = 1'b0;
    chk("hold_restart", int'({lg.Busy, lg.Valid, lg.X, lg.Y}), 18'h30000);
    cnt = 0;
    while (lg.Busy && cnt < 100) begin
      if (lg.Err) cnt += 1000;
      cnt++;
      tick();
    end
    chk("hold_second_frame", cnt, 8);
    tick();

    // Width changed mid-frame: latched copy must be kept.
    run_frame(8'd5, 8'd0, 8'd4, 5, 1'b0, 8'd9);
    chk("relatch_busy", g_busy, 20);
    chk("relatch_lines", g_lines, 4);
    chk("relatch_period", g_bad_period, 0);
    chk("relatch_valid", g_valid, 20);
    tick();

    // Asynchronous reset in the middle of blanking.
    lg.Width = 8'd4; lg.Blank = 8'd3; lg.Height = 8'd2; lg.Start = 1'b1;
    tick();
    lg.Start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_pre_blank", int'({lg.Busy, lg.Valid}), 2'b10);
    #1 nReset = 1'b0;
    #1;
    chk("rst_async_outputs", int'({lg.Busy, lg.Valid, lg.X, lg.Y, lg.Line, lg.Frame, lg.Err}), 0);
    tick(); tick();
    nReset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(lg.Busy) + int'(lg.Valid) + int'(lg.Line);
    end
    chk("rst_no_autostart", cnt, 0);
    run_frame(8'd4, 8'd3, 8'd2, 7, 1'b0, 8'd4);
    chk("rst_frame_busy", g_busy, 14);
    chk("rst_frame_y0", g_y[0], 0);
    chk("rst_frame_lines", g_lines, 2);
    chk("rst_frame_frames", g_frames, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_gen.md
# line_gen

Generates the line-synchronised pixel timing used to drive the image path. One `Start` produces one frame:
- `Height` lines, each made of `Width` active pixel cycles followed by `Blank` idle cycles;
- a single-cycle `Line` pulse at the end of every line and a `Frame` pulse at the end of the last line.

It is the source end of the `Line` interface. A line-length measurer on the same `Line` wire reads back `Width + Blank`. Bench stimulus and upstream camera emulation use this block to feed the Hough front end.

## Interface
- `W_BITS`, 8: width of the geometry inputs and of the X/Y counters.
- `nReset`  in  1  asynchronous reset, active low.
- `Clk`  in  1  single clock; all logic on its rising edge.
- `Start`  in  1  frame request; sampled only in IDLE.
- `Width`  in  8  active pixels per line; latched on accepted `Start`.
- `Blank`  in  8  blanking cycles per line; latched on accepted `Start`.
- `Height`  in  8  lines per frame; latched on accepted `Start`.
- `Busy`  out  1  high from the cycle after an accepted `Start` to the end of the frame's last cycle.
- `Valid`  out  1  high on active pixel cycles.
- `X`  out  8  pixel index within the line, 0..Width-1; holds 0 outside ACTIVE.
- `Y`  out  8  line index, 0..Height-1; holds 0 in IDLE.
- `Line`  out  1  one-cycle pulse on the final cycle of each line period.
- `Frame`  out  1  one-cycle pulse, coincident with the last `Line`.
- `Err`  out  1  one-cycle pulse when a `Start` is rejected.

## Operation
- States: IDLE, ACTIVE, BLANK.
- **IDLE**
  - `Start`=1 with a legal configuration: latch `Width`/`Blank`/`Height` and go to ACTIVE.
  - `Start`=1 with an illegal configuration: pulse `Err` next cycle and stay in IDLE.
  - Legal configuration: `Width`≥1, `Height`≥1 and `Width`+`Blank`≤255, computed 9-bit so there is no wrap.
- **ACTIVE**
  - `Valid`=1; `X` increments each cycle.
  - On `X`==Width-1: go to BLANK if Blank≠0, otherwise end the line.
- **BLANK**
  - `Valid`=0; an internal 8-bit blank counter runs 0..Blank-1.
  - On the last count, end the line.
- **End of line**
  - `Line`=1 on that cycle and `X` returns to 0.
  - If `Y`==Height-1: `Frame`=1 on the same cycle, then go to IDLE with `Y`=0 and `Busy`=0 next cycle.
  - Otherwise `Y`+1 and go to ACTIVE.
- `Start` outside IDLE is ignored: no `Err`, no relatch.
- Input changes while `Busy`=1 have no effect; the latched copies are used.
- `Width`+`Blank`=255 is the largest legal period, so an 8-bit measurer never wraps.
- Reset, including mid-frame: state IDLE and all outputs 0 immediately (asynchronous). Release resumes in IDLE and needs a new `Start`.

## Timing
- All outputs are registered.
- Latency: `Start` is sampled at edge k, so `Busy`, `Valid`, `X`=0 and `Y`=0 appear in cycle k+1.
- A frame lasts exactly Height×(Width+Blank) cycles.
- Consecutive `Line` pulses are exactly Width+Blank cycles apart.
- Back-to-back frames: `Start` can be sampled on the first IDLE cycle after `Frame`. The minimum gap between frames is therefore 1 idle cycle.
- `Err` is asserted in cycle k+1 for a rejected `Start` sampled at edge k.

## Structure
- Shared package `hough_pkg` holds:
  - the state enumeration (IDLE/ACTIVE/BLANK);
  - `W_BITS`=8;
  - the legality check as a function, reused by the measurer's checker.
- One natural sub-module, `mod_counter`: a loadable terminal-count counter with clear, enable and a `last` flag. Instantiate it three times, for X, blank and Y.
- Everything else (FSM and output registers) lives in `line_gen`.

## Test plan
- Width=4, Blank=2, Height=2, Start once:
  - `Valid` pattern 111100111100;
  - `Line` on cycles 6 and 12 after `Busy` rises;
  - `Frame` on cycle 12; `Busy` for 12 cycles;
  - a line-length measurer on `Line` reads 6.
- Width=1, Blank=0, Height=3 → `Valid` and `Line` high for 3 consecutive cycles, `Frame` on the 3rd; `X` stays 0; `Y` goes 0,1,2.
- Width=200, Blank=56 (sum 256) → `Err` pulse and `Busy` stays 0. Repeat with Width=0 and with Height=0: same result.
- `Start` held high through a frame with Width=3, Blank=1, Height=2 → no `Err` during the frame. A new frame begins on the first IDLE cycle after `Frame`, giving a 1-cycle `Busy` gap.
- Change `Width` from 5 to 9 mid-frame (Blank=0, Height=4) → every line period stays 5.
- Assert `nReset`=0 mid-BLANK → all outputs 0 immediately. After release with no `Start`, nothing is generated; after `Start`, a full frame is generated from `Y`=0.
